// File: rtl/mega_alu_mul_seq_pkg.sv
// mega_alu_mul_seq_pkg
// Shared definitions for the iterative XMEGA multiplier.
// Contents:
//   ALU_MUL_MODE_* : operation codes on the 'mode' port of mega_alu_mul_seq.
//                    They sit next to the ALU instruction codes.
//   mulDecode_t    : per-operation control bits (operand signedness, fractional shift).
//   decodeMode()   : maps a mode code to mulDecode_t. Codes 6 and 7 decode as plain MUL.
package mega_alu_mul_seq_pkg;

  localparam logic [2:0] ALU_MUL_MODE_MUL    = 3'd0;
  localparam logic [2:0] ALU_MUL_MODE_MULS   = 3'd1;
  localparam logic [2:0] ALU_MUL_MODE_MULSU  = 3'd2;
  localparam logic [2:0] ALU_MUL_MODE_FMUL   = 3'd3;
  localparam logic [2:0] ALU_MUL_MODE_FMULS  = 3'd4;
  localparam logic [2:0] ALU_MUL_MODE_FMULSU = 3'd5;

  typedef struct packed {
    logic signA;
    logic signB;
    logic frac;
  } mulDecode_t;

  // Unknown codes fall through to the all-zero decode, which is unsigned integer MUL.
  function automatic mulDecode_t decodeMode(input logic [2:0] mode);
    mulDecode_t dec;
    dec = '0;
    case (mode)
      ALU_MUL_MODE_MULS: begin
        dec.signA = 1'b1;
        dec.signB = 1'b1;
      end
      ALU_MUL_MODE_MULSU: begin
        dec.signA = 1'b1;
      end
      ALU_MUL_MODE_FMUL: begin
        dec.frac = 1'b1;
      end
      ALU_MUL_MODE_FMULS: begin
        dec.signA = 1'b1;
        dec.signB = 1'b1;
        dec.frac  = 1'b1;
      end
      ALU_MUL_MODE_FMULSU: begin
        dec.signA = 1'b1;
        dec.frac  = 1'b1;
      end
      default: dec = '0;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/mega_alu_mul_step.sv
// mega_alu_mul_step
// Combinational partial-product adder for one RUN iteration of mega_alu_mul_seq.
// Each set bit j of bits_i adds (mcand_i << j) into the accumulator high part.
// The sum is then split at the BITS_PER_CYCLE boundary:
//   - the upper bits form the new accumulator high part;
//   - the low bits are the product bits retired this iteration.
// Ports:
//   mcand_i    [WIDTH-1:0]          multiplicand magnitude
//   bits_i     [BITS_PER_CYCLE-1:0] low multiplier bits for this iteration
//   accHi_i    [WIDTH-1:0]          current accumulator high part
//   accHi_o    [WIDTH-1:0]          accumulator high part after add and shift
//   shiftOut_o [BITS_PER_CYCLE-1:0] product bits shifted out this iteration
module mega_alu_mul_step
  import mega_alu_mul_seq_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH-1:0]          mcand_i,
  input  logic [BITS_PER_CYCLE-1:0] bits_i,
  input  logic [WIDTH-1:0]          accHi_i,
  output logic [WIDTH-1:0]          accHi_o,
  output logic [BITS_PER_CYCLE-1:0] shiftOut_o
);

  // The high part stays below 2^WIDTH between iterations. Adding at most
  // (2^WIDTH-1)*(2^BITS_PER_CYCLE-1) keeps the sum below 2^(WIDTH+BITS_PER_CYCLE),
  // so this width never overflows.
  localparam int SW = WIDTH + BITS_PER_CYCLE;

  logic [SW-1:0] sum;

  // Add one shifted copy of the multiplicand for every set multiplier bit.
  always_comb begin
    sum = {{BITS_PER_CYCLE{1'b0}}, accHi_i};
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (bits_i[j]) begin
        sum = sum + (SW'(mcand_i) << j);
      end
    end
  end

  assign accHi_o    = sum[SW-1:BITS_PER_CYCLE];
  assign shiftOut_o = sum[BITS_PER_CYCLE-1:0];

endmodule

// File: rtl/mega_alu_mul_seq.sv
// mega_alu_mul_seq
// Iterative multiplier for MUL, MULS, MULSU, FMUL, FMULS and FMULSU.
// It replaces the single-cycle array multiplier with a start/busy/done handshake.
// The core stalls while busy is high. When done pulses, it writes out to R1:R0
// and the flags to SREG.
// Parameters:
//   WIDTH          operand width (even, >= 4)
//   BITS_PER_CYCLE multiplier bits retired per iteration (1, 2 or 4, dividing WIDTH)
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   start      request, accepted only while busy is low
//   mode       operation select (ALU_MUL_MODE_*), latched with start
//   in_1, in_2 multiplicand (Rd) and multiplier (Rr)
//   busy       operation in flight
//   done       one-cycle pulse when out/flag_c/flag_z are updated
//   out        2*WIDTH-bit product, held until the next FIX
//   flag_c     carry: product bit 2*WIDTH-1 before the fractional shift
//   flag_z     zero: out == 0
// Latency is WIDTH/BITS_PER_CYCLE + 1 cycles from the edge that accepts start.
module mega_alu_mul_seq
  import mega_alu_mul_seq_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           mode,
  input  logic [WIDTH-1:0]     in_1,
  input  logic [WIDTH-1:0]     in_2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out,
  output logic                 flag_c,
  output logic                 flag_z
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]      mplier_q, mplier_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic                  frac_q, frac_d;
  logic [2*WIDTH-1:0]    out_q, out_d;
  logic                  flagC_q, flagC_d;
  logic                  flagZ_q, flagZ_d;
  logic                  done_q, done_d;

  mulDecode_t                dec;
  logic [WIDTH-1:0]          aMag;
  logic [WIDTH-1:0]          bMag;
  logic                      startNeg;
  logic [WIDTH-1:0]          stepAcc;
  logic [BITS_PER_CYCLE-1:0] stepBits;
  logic [WIDTH+BITS_PER_CYCLE-1:0] shiftPair;
  logic [2*WIDTH-1:0]        prodMag;
  logic [2*WIDTH-1:0]        prodSigned;
  logic [2*WIDTH-1:0]        fixOut;

  // Operand magnitudes. |-2^(WIDTH-1)| = 2^(WIDTH-1) and every unsigned value both
  // fit in WIDTH unsigned bits, so the wrap-around negation is exact. This gives
  // the same result as taking the magnitude at WIDTH+1 bits.
  assign dec      = decodeMode(mode);
  assign aMag     = (dec.signA && in_1[WIDTH-1]) ? -in_1 : in_1;
  assign bMag     = (dec.signB && in_2[WIDTH-1]) ? -in_2 : in_2;
  assign startNeg = (dec.signA & in_1[WIDTH-1]) ^ (dec.signB & in_2[WIDTH-1]);

  mega_alu_mul_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .mcand_i    (mcand_q),
    .bits_i     (mplier_q[BITS_PER_CYCLE-1:0]),
    .accHi_i    (acc_q),
    .accHi_o    (stepAcc),
    .shiftOut_o (stepBits)
  );

  // The retired bits enter the top of the multiplier register, so {acc_q, mplier_q}
  // holds the full magnitude product once the last iteration completes.
  // Building the shift from a concatenation also covers BITS_PER_CYCLE == WIDTH.
  assign shiftPair  = {stepBits, mplier_q};
  assign prodMag    = {acc_q, mplier_q};
  assign prodSigned = neg_q ? -prodMag : prodMag;
  assign fixOut     = frac_q ? {prodSigned[2*WIDTH-2:0], 1'b0} : prodSigned;

  // Next-state and datapath control for IDLE -> RUN (N iterations) -> FIX -> IDLE.
  // done defaults low, so it is a single-cycle pulse after FIX.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    frac_d   = frac_q;
    out_d    = out_q;
    flagC_d  = flagC_q;
    flagZ_d  = flagZ_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = aMag;
          mplier_d = bMag;
          neg_d    = startNeg;
          frac_d   = dec.frac;
          acc_d    = '0;
          cnt_d    = CW'(N);
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = stepAcc;
        mplier_d = shiftPair[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        out_d   = fixOut;
        flagC_d = prodSigned[2*WIDTH-1];
        flagZ_d = (fixOut == '0);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset clears everything, including the
  // visible result, so an aborted operation never produces a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      frac_q   <= 1'b0;
      out_q    <= '0;
      flagC_q  <= 1'b0;
      flagZ_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      frac_q   <= frac_d;
      out_q    <= out_d;
      flagC_q  <= flagC_d;
      flagZ_q  <= flagZ_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign out    = out_q;
  assign flag_c = flagC_q;
  assign flag_z = flagZ_q;

endmodule

// File: tb/tb_mega_alu_mul_seq.sv
// tb_mega_alu_mul_seq
// Bench for mega_alu_mul_seq with four instances:
//   dut1  : 8/1  (main instance)
//   dut2  : 8/2
//   dut4  : 8/4
//   dut16 : 16/4
// The three 8-bit instances share mode/in_1/in_2 and each has its own start.
// Expected results are queued when an operation is launched and popped when
// the matching done pulse arrives.
module tb_mega_alu_mul_seq;
  import mega_alu_mul_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start2, start4, start16;
  logic [2:0]  mode, mode16;
  logic [7:0]  a, b;
  logic [15:0] a16, b16;

  logic        busy1, done1, c1, z1;
  logic        busy2, done2, c2, z2;
  logic        busy4, done4, c4, z4;
  logic        busy16, done16, c16, z16;
  logic [15:0] out1, out2, out4;
  logic [31:0] out16;

  int errors = 0;
  int checks = 0;

  // Each entry is {C, Z, out zero-extended to 32 bits}.
  logic [33:0] q1[$];
  logic [33:0] q2[$];
  logic [33:0] q4[$];
  logic [33:0] q16[$];

  always #5 clk = ~clk;

  mega_alu_mul_seq #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode), .in_1(a), .in_2(b),
    .busy(busy1), .done(done1), .out(out1), .flag_c(c1), .flag_z(z1));

  mega_alu_mul_seq #(.WIDTH(8), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode), .in_1(a), .in_2(b),
    .busy(busy2), .done(done2), .out(out2), .flag_c(c2), .flag_z(z2));

  mega_alu_mul_seq #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode), .in_1(a), .in_2(b),
    .busy(busy4), .done(done4), .out(out4), .flag_c(c4), .flag_z(z4));

  mega_alu_mul_seq #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .mode(mode16), .in_1(a16), .in_2(b16),
    .busy(busy16), .done(done16), .out(out16), .flag_c(c16), .flag_z(z16));

  // Reference: sign-extend by mode, multiply as integers, truncate to 2w bits.
  // C is taken before the fractional shift.
  function automatic logic [33:0] refModel(input int w, input logic [2:0] m,
                                           input logic [15:0] x, input logic [15:0] y);
    longint vx, vy, p, o, mask;
    bit sx, sy, fr;
    sx = (m == 3'd1) || (m == 3'd2) || (m == 3'd4) || (m == 3'd5);
    sy = (m == 3'd1) || (m == 3'd4);
    fr = (m == 3'd3) || (m == 3'd4) || (m == 3'd5);
    vx = longint'(x);
    vy = longint'(y);
    if (sx && x[w-1]) vx = vx - (longint'(1) << w);
    if (sy && y[w-1]) vy = vy - (longint'(1) << w);
    mask = (longint'(1) << (2 * w)) - 1;
    p = (vx * vy) & mask;
    o = fr ? ((p << 1) & mask) : p;
    return {p[2*w-1], (o == 0), o[31:0]};
  endfunction

  function automatic logic doneOf(input int which);
    case (which)
      1:       return done1;
      2:       return done2;
      4:       return done4;
      default: return done16;
    endcase
  endfunction

  function automatic logic busyOf(input int which);
    case (which)
      1:       return busy1;
      2:       return busy2;
      4:       return busy4;
      default: return busy16;
    endcase
  endfunction

  // Must be called at a negedge.
  // Pulses start on the selected 8-bit instances (sel[0]=dut1, sel[1]=dut2,
  // sel[2]=dut4) and queues the expectation for each. Returns at the negedge
  // after the accepting edge, where the latency count starts at 0.
  task automatic launch(input logic [2:0] m, input logic [7:0] x, input logic [7:0] y,
                        input logic [2:0] sel, input logic [33:0] expV);
    mode   = m;
    a      = x;
    b      = y;
    start1 = sel[0];
    start2 = sel[1];
    start4 = sel[2];
    if (sel[0]) q1.push_back(expV);
    if (sel[1]) q2.push_back(expV);
    if (sel[2]) q4.push_back(expV);
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    start4 = 1'b0;
  endtask

  // Counts negedges until done is seen, bounded by limit.
  // busyOk drops if busy is low before done, or high at done.
  task automatic waitDone(input int which, input int limit, output int lat, output bit busyOk);
    lat    = 0;
    busyOk = 1'b1;
    while (!doneOf(which) && lat < limit) begin
      if (!busyOf(which)) busyOk = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busyOf(which)) busyOk = 1'b0;
  endtask

  task automatic applyStimulus_idle();
    start1  = 1'b0;
    start2  = 1'b0;
    start4  = 1'b0;
    start16 = 1'b0;
    mode    = 3'd0;
    mode16  = 3'd0;
    a       = 8'h00;
    b       = 8'h00;
    a16     = 16'h0000;
    b16     = 16'h0000;
  endtask

  task automatic test_reset();
    applyStimulus_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done1); end
    checks++; if (out1 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_out: got %h expected 0000", out1); end
    checks++; if ({c1, z1} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00", {c1, z1}); end
    checks++; if (out16 !== 32'h0) begin errors++; $display("[TB] FAIL reset_out16: got %h expected 0", out16); end
  endtask

  task automatic test_mul_basic();
    int lat; bit bOk; logic [33:0] expV, got;
    launch(ALU_MUL_MODE_MUL, 8'hFF, 8'hFF, 3'b001, {1'b1, 1'b0, 32'h0000FE01});
    waitDone(1, 40, lat, bOk);
    checks++; if (lat != 9) begin errors++; $display("[TB] FAIL mul_latency: got %0d expected 9", lat); end
    checks++; if (!bOk) begin errors++; $display("[TB] FAIL mul_busy_window: busy not high for exactly 9 cycles"); end
    got  = {c1, z1, 16'h0000, out1};
    expV = q1.pop_front();
    checks++; if (got !== expV) begin errors++; $display("[TB] FAIL mul_result: got %h expected %h", got, expV); end
    @(negedge clk);
    checks++; if (done1 !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse_width: got %b expected 0", done1); end
  endtask

  // Directed operations from a table: signed, fractional, zero and illegal codes.
  task automatic test_directed();
    logic [2:0]  md[8] = '{ALU_MUL_MODE_MULS, ALU_MUL_MODE_MULSU, ALU_MUL_MODE_FMUL,
                           ALU_MUL_MODE_FMULS, ALU_MUL_MODE_FMULSU, ALU_MUL_MODE_MUL,
                           3'd6, 3'd7};
    logic [7:0]  xa[8] = '{8'h80, 8'hFF, 8'h40, 8'h80, 8'hC0, 8'h00, 8'hFF, 8'h80};
    logic [7:0]  xb[8] = '{8'hFF, 8'hFF, 8'h40, 8'h80, 8'h80, 8'h37, 8'h02, 8'h80};
    logic [33:0] ex[8] = '{{1'b0, 1'b0, 32'h00000080}, {1'b1, 1'b0, 32'h0000FF01},
                           {1'b0, 1'b0, 32'h00002000}, {1'b0, 1'b0, 32'h00008000},
                           {1'b1, 1'b0, 32'h0000C000}, {1'b0, 1'b1, 32'h00000000},
                           {1'b0, 1'b0, 32'h000001FE}, {1'b0, 1'b0, 32'h00004000}};
    int lat; bit bOk; logic [33:0] expV, got;
    for (int i = 0; i < 8; i++) begin
      launch(md[i], xa[i], xb[i], 3'b001, ex[i]);
      waitDone(1, 40, lat, bOk);
      got  = {c1, z1, 16'h0000, out1};
      expV = q1.pop_front();
      checks++;
      if (got !== expV || lat != 9) begin
        errors++;
        $display("[TB] FAIL directed_%0d mode %0d: got %h lat %0d expected %h lat 9", i, md[i], got, lat, expV);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_while_busy();
    int lat; bit bOk; bit spurious; logic [33:0] expV, got;
    launch(ALU_MUL_MODE_MUL, 8'h12, 8'h34, 3'b001, {1'b0, 1'b0, 32'h000003A8});
    repeat (3) @(negedge clk);
    mode   = ALU_MUL_MODE_MULS;
    a      = 8'hAA;
    b      = 8'h55;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    waitDone(1, 40, lat, bOk);
    checks++; if (lat != 5) begin errors++; $display("[TB] FAIL busy_start_latency: got %0d expected 5", lat); end
    got  = {c1, z1, 16'h0000, out1};
    expV = q1.pop_front();
    checks++; if (got !== expV) begin errors++; $display("[TB] FAIL busy_start_result: got %h expected %h", got, expV); end
    spurious = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done1 || busy1) spurious = 1'b1;
    end
    checks++; if (spurious) begin errors++; $display("[TB] FAIL busy_start_ignored: got extra operation expected none"); end
  endtask

  task automatic test_back_to_back();
    int lat; bit bOk; logic [33:0] expV, got;
    launch(ALU_MUL_MODE_MUL, 8'h0F, 8'h0F, 3'b001, {1'b0, 1'b0, 32'h000000E1});
    waitDone(1, 40, lat, bOk);
    got  = {c1, z1, 16'h0000, out1};
    expV = q1.pop_front();
    checks++; if (got !== expV) begin errors++; $display("[TB] FAIL b2b_first: got %h expected %h", got, expV); end
    launch(ALU_MUL_MODE_FMUL, 8'h80, 8'h80, 3'b001, {1'b0, 1'b0, 32'h00008000});
    checks++;
    if (out1 !== 16'h00E1 || done1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_hold: got out %h done %b busy %b expected 00e1 0 1", out1, done1, busy1);
    end
    waitDone(1, 40, lat, bOk);
    checks++; if (lat != 9) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 9", lat); end
    got  = {c1, z1, 16'h0000, out1};
    expV = q1.pop_front();
    checks++; if (got !== expV) begin errors++; $display("[TB] FAIL b2b_second: got %h expected %h", got, expV); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    bit spurious;
    launch(ALU_MUL_MODE_MUL, 8'h55, 8'h33, 3'b001, {1'b0, 1'b0, 32'h000010EF});
    void'(q1.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL rst_run_busy: got %b expected 0", busy1); end
    checks++; if (out1 !== 16'h0000) begin errors++; $display("[TB] FAIL rst_run_out: got %h expected 0000", out1); end
    spurious = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done1) spurious = 1'b1;
    end
    checks++; if (spurious) begin errors++; $display("[TB] FAIL rst_run_done: got done pulse expected none"); end
  endtask

  task automatic test_sweep();
    int lat; bit bOk; logic [33:0] expV, got;
    launch(ALU_MUL_MODE_MUL, 8'hFF, 8'hFF, 3'b010, {1'b1, 1'b0, 32'h0000FE01});
    waitDone(2, 40, lat, bOk);
    got  = {c2, z2, 16'h0000, out2};
    expV = q2.pop_front();
    checks++;
    if (got !== expV || lat != 5 || !bOk) begin
      errors++; $display("[TB] FAIL sweep_8_2: got %h lat %0d expected %h lat 5", got, lat, expV);
    end
    @(negedge clk);
    launch(ALU_MUL_MODE_MULS, 8'h80, 8'hFF, 3'b100, {1'b0, 1'b0, 32'h00000080});
    waitDone(4, 40, lat, bOk);
    got  = {c4, z4, 16'h0000, out4};
    expV = q4.pop_front();
    checks++;
    if (got !== expV || lat != 3 || !bOk) begin
      errors++; $display("[TB] FAIL sweep_8_4: got %h lat %0d expected %h lat 3", got, lat, expV);
    end
    @(negedge clk);
    mode16  = ALU_MUL_MODE_MULS;
    a16     = 16'h8000;
    b16     = 16'h8000;
    start16 = 1'b1;
    q16.push_back({1'b0, 1'b0, 32'h40000000});
    @(negedge clk);
    start16 = 1'b0;
    waitDone(16, 40, lat, bOk);
    got  = {c16, z16, out16};
    expV = q16.pop_front();
    checks++;
    if (got !== expV || lat != 5 || !bOk) begin
      errors++; $display("[TB] FAIL sweep_16_4: got %h lat %0d expected %h lat 5", got, lat, expV);
    end
    @(negedge clk);
  endtask

  // All three 8-bit instances run the same random operation. Each done is
  // matched against its own queue and its expected latency (3, 5, 9).
  task automatic test_random();
    logic [2:0] m; logic [7:0] x, y; logic [33:0] expV, got;
    bit seen1, seen2, seen4;
    for (int n = 0; n < 400; n++) begin
      m = 3'($urandom_range(0, 7));
      x = 8'($urandom);
      y = 8'($urandom);
      launch(m, x, y, 3'b111, refModel(8, m, {8'h00, x}, {8'h00, y}));
      seen1 = 1'b0; seen2 = 1'b0; seen4 = 1'b0;
      for (int cyc = 0; cyc < 15 && !seen1; cyc++) begin
        if (done4) begin
          checks++;
          got = {c4, z4, 16'h0000, out4};
          if (q4.size() == 0) begin errors++; $display("[TB] FAIL rand_8_4 op %0d: got unexpected done expected none", n); end
          else begin
            expV = q4.pop_front(); seen4 = 1'b1;
            if (got !== expV || cyc != 3) begin errors++; $display("[TB] FAIL rand_8_4 op %0d: got %h lat %0d expected %h lat 3", n, got, cyc, expV); end
          end
        end
        if (done2) begin
          checks++;
          got = {c2, z2, 16'h0000, out2};
          if (q2.size() == 0) begin errors++; $display("[TB] FAIL rand_8_2 op %0d: got unexpected done expected none", n); end
          else begin
            expV = q2.pop_front(); seen2 = 1'b1;
            if (got !== expV || cyc != 5) begin errors++; $display("[TB] FAIL rand_8_2 op %0d: got %h lat %0d expected %h lat 5", n, got, cyc, expV); end
          end
        end
        if (done1) begin
          checks++;
          got = {c1, z1, 16'h0000, out1};
          if (q1.size() == 0) begin errors++; $display("[TB] FAIL rand_8_1 op %0d: got unexpected done expected none", n); end
          else begin
            expV = q1.pop_front(); seen1 = 1'b1;
            if (got !== expV || cyc != 9) begin errors++; $display("[TB] FAIL rand_8_1 op %0d: got %h lat %0d expected %h lat 9", n, got, cyc, expV); end
          end
        end
        if (!seen1) @(negedge clk);
      end
      if (!(seen1 && seen2 && seen4)) begin
        checks++; errors++;
        $display("[TB] FAIL rand_timeout op %0d: got done %b%b%b expected 111", n, seen1, seen2, seen4);
        q1.delete(); q2.delete(); q4.delete();
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus_idle();
    test_reset();
    test_mul_basic();
    test_directed();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
